// File: rtl/pwm_pkg.sv
// Shared constants, FSM encoding and sizing helper for the PWM duty decoder.
package pwm_pkg;

  localparam int unsigned PERIOD  = 8;
  localparam int unsigned DUTY_W  = 3;
  localparam int unsigned TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  // Counters must hold TIMEOUT itself so a frame that long always times out.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pwm_duty_channel.sv
// One PWM line receiver: frame measurement, duty decode, period and static-line checks.
module pwm_duty_channel #(
  parameter int unsigned PERIOD  = pwm_pkg::PERIOD,
  parameter int unsigned DUTY_W  = pwm_pkg::DUTY_W,
  parameter int unsigned TIMEOUT = pwm_pkg::TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              frame_err,
  output logic              stuck
);
  import pwm_pkg::*;

  localparam int unsigned   CW      = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);
  localparam logic [CW-1:0] PER_VAL = CW'(PERIOD);
  localparam logic [CW-1:0] ONE     = CW'(1);

  state_e            state_q, state_d;
  logic              pwm_q;
  logic [CW-1:0]     per_cnt_q, per_cnt_d;
  logic [CW-1:0]     hi_cnt_q, hi_cnt_d;
  logic [CW-1:0]     timer_q, timer_d;
  logic              low_rep_q, low_rep_d;
  logic [DUTY_W-1:0] duty_d;
  logic              valid_d, frame_err_d, stuck_d;
  logic              rise, fall, edge_seen, low_to, high_to;

  assign rise      = pwm & ~pwm_q;
  assign fall      = ~pwm & pwm_q;
  assign edge_seen = rise | fall;
  // An edge in the same cycle as an expiring timer suppresses the timeout.
  assign low_to    = ~edge_seen & (timer_q == TO_VAL) & ~pwm & ~low_rep_q;
  assign high_to   = ~edge_seen & (timer_q == TO_VAL) & pwm;

  always_comb begin
    state_d     = state_q;
    per_cnt_d   = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + ONE;
    hi_cnt_d    = (pwm && hi_cnt_q != CNT_MAX) ? hi_cnt_q + ONE : hi_cnt_q;
    timer_d     = edge_seen ? '0 : ((timer_q == TO_VAL) ? timer_q : timer_q + ONE);
    low_rep_d   = edge_seen ? 1'b0 : low_rep_q;
    duty_d      = duty;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    stuck_d     = fall ? 1'b0 : stuck;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d   = ST_HIGH;
          per_cnt_d = ONE;
          hi_cnt_d  = ONE;
        end
      end
      ST_HIGH: begin
        if (fall) state_d = ST_LOW;
      end
      ST_LOW: begin
        // Rise closes the frame; the rise cycle is cycle 1 of the next one.
        if (rise) begin
          if (per_cnt_q == PER_VAL) begin
            duty_d  = hi_cnt_q[DUTY_W-1:0];
            valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d   = ST_HIGH;
          per_cnt_d = ONE;
          hi_cnt_d  = ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (low_to) begin
      duty_d    = '0;
      valid_d   = 1'b1;
      low_rep_d = 1'b1;
      state_d   = ST_IDLE;
    end
    if (high_to) begin
      stuck_d = 1'b1;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pwm_q     <= 1'b0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      timer_q   <= '0;
      low_rep_q <= 1'b0;
      duty      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      stuck     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pwm_q     <= pwm;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      timer_q   <= timer_d;
      low_rep_q <= low_rep_d;
      duty      <= duty_d;
      valid     <= valid_d;
      frame_err <= frame_err_d;
      stuck     <= stuck_d;
    end
  end

endmodule

// File: rtl/pwm_duty_decoder.sv
// Two independent PWM duty receivers for the right and left motor lines.
module pwm_duty_decoder #(
  parameter int unsigned PERIOD  = pwm_pkg::PERIOD,
  parameter int unsigned DUTY_W  = pwm_pkg::DUTY_W,
  parameter int unsigned TIMEOUT = pwm_pkg::TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_r,
  input  logic              pwm_l,
  output logic [DUTY_W-1:0] duty_r,
  output logic [DUTY_W-1:0] duty_l,
  output logic              valid_r,
  output logic              valid_l,
  output logic              frame_err_r,
  output logic              frame_err_l,
  output logic              stuck_r,
  output logic              stuck_l
);

  pwm_duty_channel #(.PERIOD(PERIOD), .DUTY_W(DUTY_W), .TIMEOUT(TIMEOUT)) u_ch_r (
    .clk       (clk),
    .rst       (rst),
    .pwm       (pwm_r),
    .duty      (duty_r),
    .valid     (valid_r),
    .frame_err (frame_err_r),
    .stuck     (stuck_r)
  );

  pwm_duty_channel #(.PERIOD(PERIOD), .DUTY_W(DUTY_W), .TIMEOUT(TIMEOUT)) u_ch_l (
    .clk       (clk),
    .rst       (rst),
    .pwm       (pwm_l),
    .duty      (duty_l),
    .valid     (valid_l),
    .frame_err (frame_err_l),
    .stuck     (stuck_l)
  );

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Scoreboard bench for pwm_duty_decoder: expected frame reports queued as lines are driven.
module tb_pwm_duty_decoder;
  import pwm_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pwm_r = 1'b0;
  logic              pwm_l = 1'b0;
  logic [DUTY_W-1:0] duty_r, duty_l;
  logic              valid_r, valid_l, frame_err_r, frame_err_l, stuck_r, stuck_l;

  pwm_duty_decoder dut (
    .clk(clk), .rst(rst), .pwm_r(pwm_r), .pwm_l(pwm_l),
    .duty_r(duty_r), .duty_l(duty_l), .valid_r(valid_r), .valid_l(valid_l),
    .frame_err_r(frame_err_r), .frame_err_l(frame_err_l),
    .stuck_r(stuck_r), .stuck_l(stuck_l)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit err;
    int duty;
  } ev_t;

  ev_t exp_r[$];
  ev_t exp_l[$];
  ev_t mr, ml;
  int  checks = 0;
  int  errors = 0;

  // Line-level expectation state: a report is due at each rise after an arming rise.
  bit prev_r = 0, prev_l = 0, armed_r = 0, armed_l = 0;
  int rise_r = 0, rise_l = 0, hacc_r = 0, hacc_l = 0, ld_r = 0, ld_l = 0;

  task automatic model_step(input bit lvl, input int k, inout bit prev, inout bit armed,
                            inout int rise_k, inout int hacc, inout int last_duty,
                            output bit push, output ev_t ev);
    push = 0;
    ev.cyc = k; ev.err = 0; ev.duty = 0;
    if (lvl && !prev) begin
      if (armed) begin
        push = 1;
        if (k - rise_k == int'(PERIOD)) begin
          ev.duty   = hacc;
          last_duty = hacc;
        end else begin
          ev.err  = 1;
          ev.duty = last_duty;
        end
      end
      armed  = 1;
      rise_k = k;
      hacc   = 0;
    end
    if (lvl) hacc++;
    prev = lvl;
  endtask

  task automatic drive(input logic r, input logic l);
    int  k;
    bit  p;
    ev_t e;
    k = cyc + 1;
    model_step(r, k, prev_r, armed_r, rise_r, hacc_r, ld_r, p, e);
    if (p) exp_r.push_back(e);
    model_step(l, k, prev_l, armed_l, rise_l, hacc_l, ld_l, p, e);
    if (p) exp_l.push_back(e);
    pwm_r = r;
    pwm_l = l;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int hr, input int pr, input int hl, input int pl,
                     input int n, input int ph);
    for (int c = 0; c < n; c++)
      drive(((c + ph) % pr) < hr, ((c + ph) % pl) < hl);
  endtask

  task automatic do_reset(input logic r, input logic l, input int n);
    rst = 1'b1; pwm_r = r; pwm_l = l;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    prev_r = 0; prev_l = 0; armed_r = 0; armed_l = 0;
    hacc_r = 0; hacc_l = 0; ld_r = 0; ld_l = 0;
  endtask

  // Scoreboard: every report pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (valid_r || frame_err_r) begin
      checks++;
      if (exp_r.size() == 0) begin
        errors++;
        $display("FAIL unexpected_r cyc=%0d valid=%b err=%b duty=%0d", cyc, valid_r, frame_err_r, duty_r);
      end else begin
        mr = exp_r.pop_front();
        if (cyc !== mr.cyc || frame_err_r !== mr.err || valid_r === mr.err || duty_r !== DUTY_W'(mr.duty)) begin
          errors++;
          $display("FAIL report_r got cyc=%0d valid=%b err=%b duty=%0d exp cyc=%0d err=%b duty=%0d",
                   cyc, valid_r, frame_err_r, duty_r, mr.cyc, mr.err, mr.duty);
        end
      end
    end
    if (valid_l || frame_err_l) begin
      checks++;
      if (exp_l.size() == 0) begin
        errors++;
        $display("FAIL unexpected_l cyc=%0d valid=%b err=%b duty=%0d", cyc, valid_l, frame_err_l, duty_l);
      end else begin
        ml = exp_l.pop_front();
        if (cyc !== ml.cyc || frame_err_l !== ml.err || valid_l === ml.err || duty_l !== DUTY_W'(ml.duty)) begin
          errors++;
          $display("FAIL report_l got cyc=%0d valid=%b err=%b duty=%0d exp cyc=%0d err=%b duty=%0d",
                   cyc, valid_l, frame_err_l, duty_l, ml.cyc, ml.err, ml.duty);
        end
      end
    end
  end

  task automatic test_reset();
    do_reset(1'b0, 1'b0, 3);
    checks++;
    if (duty_r !== 3'd0 || duty_l !== 3'd0) begin
      errors++; $display("FAIL reset_duty got r=%0d l=%0d exp 0", duty_r, duty_l);
    end
    checks++;
    if ({valid_r, valid_l, frame_err_r, frame_err_l, stuck_r, stuck_l} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 000000",
                         {valid_r, valid_l, frame_err_r, frame_err_l, stuck_r, stuck_l});
    end
  endtask

  task automatic test_steady_low_timeout();
    ev_t e;
    e.cyc = cyc + int'(TIMEOUT) + 1; e.err = 0; e.duty = 0;
    exp_l.push_back(e);
    run(3, 8, 0, 8, 120, 0);
    @(negedge clk); #1;
    checks++;
    if (duty_r !== 3'd3) begin errors++; $display("FAIL steady_duty_r got %0d exp 3", duty_r); end
    checks++;
    if (exp_r.size() != 0 || exp_l.size() != 0) begin
      errors++; $display("FAIL steady_pending got r=%0d l=%0d exp 0", exp_r.size(), exp_l.size());
    end
  endtask

  task automatic test_dual();
    run(7, 8, 1, 8, 64, 0);
    @(negedge clk); #1;
    checks++;
    if (duty_r !== 3'd7) begin errors++; $display("FAIL dual_duty_r got %0d exp 7", duty_r); end
    checks++;
    if (duty_l !== 3'd1) begin errors++; $display("FAIL dual_duty_l got %0d exp 1", duty_l); end
    checks++;
    if (exp_r.size() != 0 || exp_l.size() != 0) begin
      errors++; $display("FAIL dual_pending got r=%0d l=%0d exp 0", exp_r.size(), exp_l.size());
    end
  endtask

  task automatic test_frame_err();
    run(5, 8, 1, 8, 32, 0);
    run(3, 6, 1, 8, 48, 0);
    @(negedge clk); #1;
    checks++;
    if (duty_r !== 3'd5) begin errors++; $display("FAIL ferr_hold_duty got %0d exp 5", duty_r); end
    checks++;
    if (exp_r.size() != 0 || exp_l.size() != 0) begin
      errors++; $display("FAIL ferr_pending got r=%0d l=%0d exp 0", exp_r.size(), exp_l.size());
    end
  endtask

  task automatic test_stuck();
    run(4, 8, 1, 8, 32, 0);
    run(1, 1, 1, 8, 17, 0);
    checks++;
    if (stuck_r !== 1'b0) begin errors++; $display("FAIL stuck_early got %b exp 0", stuck_r); end
    run(1, 1, 1, 8, 1, 17);
    checks++;
    if (stuck_r !== 1'b1) begin errors++; $display("FAIL stuck_set got %b exp 1", stuck_r); end
    checks++;
    if (duty_r !== 3'd4) begin errors++; $display("FAIL stuck_duty got %0d exp 4", duty_r); end
    run(1, 1, 1, 8, 2, 18);
    armed_r = 0;
    run(0, 8, 1, 8, 1, 20);
    checks++;
    if (stuck_r !== 1'b0) begin errors++; $display("FAIL stuck_clear got %b exp 0", stuck_r); end
    run(0, 8, 1, 8, 3, 21);
    run(2, 8, 1, 8, 24, 0);
    @(negedge clk); #1;
    checks++;
    if (duty_r !== 3'd2) begin errors++; $display("FAIL resume_duty got %0d exp 2", duty_r); end
    checks++;
    if (exp_r.size() != 0 || exp_l.size() != 0 || stuck_l !== 1'b0) begin
      errors++; $display("FAIL stuck_pending got r=%0d l=%0d stuck_l=%b exp 0 0 0",
                         exp_r.size(), exp_l.size(), stuck_l);
    end
  endtask

  task automatic test_reset_mid();
    run(6, 8, 1, 8, 18, 0);
    do_reset(1'b1, 1'b0, 1);
    checks++;
    if ({duty_r, duty_l, valid_r, valid_l, frame_err_r, frame_err_l, stuck_r, stuck_l} !== 12'b0) begin
      errors++; $display("FAIL midrst_outputs got duty_r=%0d duty_l=%0d flags=%b exp all 0", duty_r, duty_l,
                         {valid_r, valid_l, frame_err_r, frame_err_l, stuck_r, stuck_l});
    end
    run(6, 8, 1, 8, 24, 3);
    @(negedge clk); #1;
    checks++;
    if (duty_r !== 3'd6 || duty_l !== 3'd1) begin
      errors++; $display("FAIL midrst_duty got r=%0d l=%0d exp 6 1", duty_r, duty_l);
    end
    checks++;
    if (exp_r.size() != 0 || exp_l.size() != 0) begin
      errors++; $display("FAIL midrst_pending got r=%0d l=%0d exp 0", exp_r.size(), exp_l.size());
    end
  endtask

  initial begin
    test_reset();
    test_steady_low_timeout();
    test_dual();
    test_frame_err();
    test_stuck();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
